// File: rtl/ifb_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package ifb_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } ifb_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/ifb_fifo.sv
// Prefetch FIFO: DEPTH entries (power of two), flush wins over push/pop, NOP when empty.
module ifb_fifo
  import ifb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [INSTR_W-1:0] din,
  output logic [INSTR_W-1:0] dout,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty
);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [AW-1:0]      rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]      count_reg;
  logic               push_ok, pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

  assign dout  = empty ? NOP_INSTR : mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch/prefetch stage: sequential fetch FSM, prefetch FIFO and redirect handling.
// Optional IFB_BYPASS_EN: forwards an ack word straight to the decoder when the FIFO is empty.
module instr_fetch_buffer
  import ifb_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] cpu_instruction,
  output logic        instruction_RDY_BSY,
  input  logic        decoder_rdy_bsy
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifb_state_e   state_reg, state_next;
  logic [31:0]  fetch_addr_reg, fetch_addr_next;
  logic [31:0]  imem_addr_reg, imem_addr_next;
  logic         imem_req_reg, imem_req_next;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [INSTR_W-1:0] fifo_dout;
  logic               resp_keep, bypass_hit, bypass_take, space;
  logic [CW:0]        occ_next;

  // A response is kept only for a live request that is not being redirected away.
  assign resp_keep = (state_reg == REQ) && imem_ack && !redirect;

`ifdef IFB_BYPASS_EN
  assign bypass_hit = resp_keep && fifo_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  assign bypass_take = bypass_hit && decoder_rdy_bsy;
  assign fifo_push   = resp_keep && !bypass_take && (!fifo_full || fifo_pop);
  assign fifo_pop    = !fifo_empty && decoder_rdy_bsy && !redirect;
  assign occ_next    = {1'b0, fifo_count} + (CW+1)'(fifo_push) - (CW+1)'(fifo_pop);
  assign space       = occ_next < (CW+1)'(DEPTH);

  ifb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (cpu_clk),
    .srst  (cpu_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .din   (imem_rdata),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next      = state_reg;
    fetch_addr_next = fetch_addr_reg;
    imem_req_next   = imem_req_reg;
    imem_addr_next  = imem_addr_reg;
    if (redirect) begin
      fetch_addr_next = word_align(redirect_addr);
      case (state_reg)
        REQ: begin
          if (imem_ack) begin
            state_next    = IDLE;
            imem_req_next = 1'b0;
          end else begin
            state_next    = DROP;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state_next    = IDLE;
            imem_req_next = 1'b0;
          end
        end
        default: ;
      endcase
    end else begin
      case (state_reg)
        IDLE: begin
          if (space) begin
            state_next     = REQ;
            imem_req_next  = 1'b1;
            imem_addr_next = fetch_addr_reg;
          end
        end
        REQ: begin
          if (imem_ack) begin
            fetch_addr_next = fetch_addr_reg + PC_STEP;
            if (space) begin
              imem_addr_next = fetch_addr_reg + PC_STEP;
            end else begin
              state_next    = IDLE;
              imem_req_next = 1'b0;
            end
          end
        end
        DROP: begin
          if (imem_ack) begin
            state_next    = IDLE;
            imem_req_next = 1'b0;
          end
        end
        default: begin
          state_next    = IDLE;
          imem_req_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_reg      <= IDLE;
      fetch_addr_reg <= RESET_PC;
      imem_req_reg   <= 1'b0;
      imem_addr_reg  <= RESET_PC;
    end else begin
      state_reg      <= state_next;
      fetch_addr_reg <= fetch_addr_next;
      imem_req_reg   <= imem_req_next;
      imem_addr_reg  <= imem_addr_next;
    end
  end

  assign imem_req            = imem_req_reg;
  assign imem_addr           = imem_addr_reg;
  assign cpu_instruction     = bypass_hit ? imem_rdata : fifo_dout;
  assign instruction_RDY_BSY = bypass_hit || !fifo_empty;

endmodule
